tlb_op_unit: RTL and testbench
==============================

Name: tlb_op_unit

Overview:
- CP0-side initiator for the TLB maintenance interface of the MMU.
- Executes TLBR, TLBWI, TLBWR and TLBP. Drives `tlbrw_index`/`tlbrw_we`/`tlbrw_wdata` and `tlbp_entry_hi`, and samples `tlbrw_rdata`/`tlbp_index`.
- Owns the Random register and returns CP0 writeback values through a valid/ready response.
- Sits between the pipeline's CP0 stage and the mmu.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; must be a power of two, 2..64.
- READ_LAT, 1, cycles from presenting `tlbrw_index` to `tlbrw_rdata` being valid (1..4).
- PROBE_LAT, 1, cycles from presenting `tlbp_entry_hi` to `tlbp_index` being valid (1..4).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  unit can accept a request
- req_op  in  tlb_op_t  TLB_OP_R / TLB_OP_WI / TLB_OP_WR / TLB_OP_P
- cp0_index  in  32  CP0 Index
- cp0_entryhi  in  32  CP0 EntryHi
- cp0_entrylo0  in  32  CP0 EntryLo0
- cp0_entrylo1  in  32  CP0 EntryLo1
- cp0_wired  in  32  CP0 Wired
- wired_we  in  1  CP0 Wired being written this cycle
- random_out  out  32  CP0 Random value
- tlbrw_index  out  tlb_index_t  entry index for read/write
- tlbrw_we  out  1  write strobe
- tlbrw_wdata  out  tlb_entry_t  entry to write
- tlbrw_rdata  in  tlb_entry_t  entry read
- tlbp_entry_hi  out  32  probe key
- tlbp_index  in  32  probe result; bit31 = miss, low bits = index
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_op  out  tlb_op_t  operation completed
- resp_entryhi, resp_entrylo0, resp_entrylo1  out  32 each  TLBR writeback
- resp_index  out  32  TLBP writeback
- tlb_flush  out  1  one-cycle pulse after any TLB write

Behaviour:
- Reset (resetn low, async):
  - State goes to IDLE. `req_ready`=1.
  - All other outputs 0, including `tlbrw_we`, `resp_valid` and `tlb_flush`.
  - `random_out`=TLB_ENTRIES-1.
  - Reset mid-operation aborts the operation; no response is produced and no write is issued.
- States: IDLE, RD_WAIT, PR_WAIT, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, capture `req_op` and all cp0_* inputs. For TLB_OP_WR, also capture the current Random value.
  - Next state by operation: R → RD_WAIT; P → PR_WAIT; WI/WR → WRITE.
- RD_WAIT:
  - `tlbrw_index` = captured `cp0_index[$clog2(TLB_ENTRIES)-1:0]`.
  - Stay READ_LAT cycles, then register unpacked `tlbrw_rdata` into `resp_entryhi`/`resp_entrylo0`/`resp_entrylo1`, and go to RESP.
- PR_WAIT:
  - `tlbp_entry_hi` = captured EntryHi.
  - After PROBE_LAT cycles, register `resp_index` = `{tlbp_index[31], 31'b0 | tlbp_index[$clog2(TLB_ENTRIES)-1:0]}`, then go to RESP.
- WRITE:
  - Exactly one cycle with `tlbrw_we`=1.
  - `tlbrw_index` = captured Index low bits (WI) or captured Random (WR).
  - `tlbrw_wdata` = packed entry.
  - Next cycle: `tlb_flush`=1 for one cycle and state goes to RESP.
- RESP:
  - `resp_valid`=1; `resp_op` and data are stable until `resp_ready`.
  - On `resp_valid & resp_ready`, go to IDLE. No new request is accepted that same cycle.
- Outside RD_WAIT/WRITE, `tlbrw_index` holds its last value. `tlbrw_we` is 0 everywhere except WRITE.
- Packing (EntryHi/EntryLo → `tlb_entry_t`):
  - vpn2 = EntryHi[31:13]; asid = EntryHi[7:0].
  - pfn = Lo[25:6]; c = Lo[5:3]; d = Lo[2]; v = Lo[1].
  - G = Lo0[0] & Lo1[0].
- Unpacking (`tlb_entry_t` → registers):
  - EntryHi = {vpn2, 5'b0, asid}.
  - Lo = {6'b0, pfn, c, d, v, G}.
- Random:
  - Updates every cycle independently of the FSM.
  - Next value: if `wired_we`, TLB_ENTRIES-1. Else if Random ≤ Wired or Random == 0, TLB_ENTRIES-1. Else Random-1.
  - If Wired ≥ TLB_ENTRIES, Random stays TLB_ENTRIES-1.
  - `random_out` = zero-extended Random.
- Index inputs ≥ TLB_ENTRIES are truncated to low bits; no error is raised.

Decomposition:
- Add to the cpu package:
  - `tlb_op_t` (2-bit enum)
  - `tlb_index_t` width tied to TLB_ENTRIES
  - `tlb_entry_t` fields vpn2/asid/G/pfn0/c0/d0/v0/pfn1/c1/d1/v1
  - pack/unpack functions
- One sub-module: `tlb_random_reg` (Random counter with Wired wrap).

Test Plan:
- After reset deasserts → `random_out`=15 and `req_ready`=1; cycle by cycle Random=15,14,…,0,15 with Wired=0. With Wired=4: 15…4,15.
- TLBWI with Index=5, EntryHi=0x0040_2012, Lo0=0x0000_0107, Lo1=0x0000_0147 → exactly one `tlbrw_we` cycle, index 5, vpn2=0x00201, asid=0x12, G=1. Then `tlb_flush` pulse, then `resp_valid` with `resp_op`=WI.
- TLBR on index 5 after the write, READ_LAT=2 → `resp_entryhi`=0x0040_2012, `resp_entrylo0`=0x0000_0107, `resp_entrylo1`=0x0000_0147.
- TLBP with model `tlbp_index`=0x8000_0000 → `resp_index`=0x8000_0000. With model hit at index 3 → `resp_index`=0x0000_0003.
- TLBWR with Random=9 at accept → write lands at index 9 even though Random changes while waiting. Asserting `wired_we` on the same cycle as accept still uses 9.
- Hold `resp_ready`=0 for 5 cycles → response is stable and `req_ready`=0. Pulsing resetn low in WRITE → no `tlbrw_we`, no `resp_valid`, IDLE afterwards.

Source files
------------

// File: rtl/tlb_op_unit_pkg.sv
// rtl/tlb_op_unit_pkg.sv - TLB maintenance types, entry packing and unpacking helpers
package tlb_op_unit_pkg;

    // Index bus is sized for the largest supported TLB (64 entries); smaller TLBs zero-extend.
    localparam int TLB_INDEX_W = 6;

    typedef enum logic [1:0] {
        TLB_OP_R  = 2'd0,
        TLB_OP_WI = 2'd1,
        TLB_OP_WR = 2'd2,
        TLB_OP_P  = 2'd3
    } tlb_op_t;

    typedef logic [TLB_INDEX_W-1:0] tlb_index_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_PR_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } tlb_state_t;

    // Global bit is only set when both halves of the pair are global.
    function automatic tlb_entry_t tlb_pack(input logic [31:0] hi,
                                            input logic [31:0] lo0,
                                            input logic [31:0] lo1);
        tlb_entry_t e;
        e.vpn2 = hi[31:13];
        e.asid = hi[7:0];
        e.g    = lo0[0] & lo1[0];
        e.pfn0 = lo0[25:6];
        e.c0   = lo0[5:3];
        e.d0   = lo0[2];
        e.v0   = lo0[1];
        e.pfn1 = lo1[25:6];
        e.c1   = lo1[5:3];
        e.d1   = lo1[2];
        e.v1   = lo1[1];
        return e;
    endfunction

    function automatic logic [31:0] tlb_unpack_hi(input tlb_entry_t e);
        return {e.vpn2, 5'b0, e.asid};
    endfunction

    function automatic logic [31:0] tlb_unpack_lo0(input tlb_entry_t e);
        return {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g};
    endfunction

    function automatic logic [31:0] tlb_unpack_lo1(input tlb_entry_t e);
        return {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g};
    endfunction

endpackage

// File: rtl/tlb_op_unit_if.sv
// rtl/tlb_op_unit_if.sv - CP0-stage request/response bus of the TLB operation unit
interface tlb_op_unit_if;
    import tlb_op_unit_pkg::*;

    logic        req_valid;
    logic        req_ready;
    tlb_op_t     req_op;
    logic [31:0] cp0_index;
    logic [31:0] cp0_entryhi;
    logic [31:0] cp0_entrylo0;
    logic [31:0] cp0_entrylo1;

    logic        resp_valid;
    logic        resp_ready;
    tlb_op_t     resp_op;
    logic [31:0] resp_entryhi;
    logic [31:0] resp_entrylo0;
    logic [31:0] resp_entrylo1;
    logic [31:0] resp_index;

    // Pipeline side: issues operations and consumes writebacks.
    modport master (
        output req_valid, req_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, resp_ready,
        input  req_ready, resp_valid, resp_op, resp_entryhi, resp_entrylo0, resp_entrylo1, resp_index
    );

    // Unit side.
    modport slave (
        input  req_valid, req_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, resp_ready,
        output req_ready, resp_valid, resp_op, resp_entryhi, resp_entrylo0, resp_entrylo1, resp_index
    );
endinterface

// File: rtl/tlb_random_reg.sv
// rtl/tlb_random_reg.sv - CP0 Random counter that wraps at Wired
module tlb_random_reg #(
    parameter int TLB_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [31:0]                    cp0_wired_i,
    input  logic                           wired_we_i,
    output logic [$clog2(TLB_ENTRIES)-1:0] random_o
);
    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

    logic [IW-1:0] random_q;
    logic [IW-1:0] random_d;

    // Count down, reloading at the top when reaching Wired, zero, or when Wired is rewritten.
    always_comb begin
        random_d = random_q - IW'(1);
        if (wired_we_i) begin
            random_d = TOP;
        end else if ((32'(random_q) <= cp0_wired_i) || (random_q == '0)) begin
            random_d = TOP;
        end
    end

    // Random register, free-running every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;
endmodule

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - CP0-side initiator for TLBR/TLBWI/TLBWR/TLBP towards the MMU
module tlb_op_unit
    import tlb_op_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int READ_LAT    = 1,
    parameter int PROBE_LAT   = 1
) (
    input  logic                clk,
    input  logic                resetn,
    tlb_op_unit_if.slave        op_if,
    input  logic [31:0]         cp0_wired,
    input  logic                wired_we,
    output logic [31:0]         random_out,
    output tlb_index_t          tlbrw_index,
    output logic                tlbrw_we,
    output tlb_entry_t          tlbrw_wdata,
    input  tlb_entry_t          tlbrw_rdata,
    output logic [31:0]         tlbp_entry_hi,
    input  logic [31:0]         tlbp_index,
    output logic                tlb_flush
);
    localparam int IW = $clog2(TLB_ENTRIES);

    tlb_state_t  state_q, state_d;
    tlb_op_t     op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo0_q, lo0_d;
    logic [31:0] lo1_q, lo1_d;
    tlb_index_t  index_q, index_d;
    logic [2:0]  lat_q, lat_d;
    logic        flush_q, flush_d;
    logic [31:0] resp_hi_q, resp_hi_d;
    logic [31:0] resp_lo0_q, resp_lo0_d;
    logic [31:0] resp_lo1_q, resp_lo1_d;
    logic [31:0] resp_index_q, resp_index_d;
    logic [IW-1:0] random_q;

    // Index bits above the TLB size are ignored by design.
    logic unused_bits;
    assign unused_bits = ^{op_if.cp0_index[31:IW], tlbp_index[30:IW]};

    tlb_random_reg #(
        .TLB_ENTRIES (TLB_ENTRIES)
    ) u_random (
        .clk         (clk),
        .resetn      (resetn),
        .cp0_wired_i (cp0_wired),
        .wired_we_i  (wired_we),
        .random_o    (random_q)
    );

    // Next-state and datapath capture; WR latches Random at accept so later counting cannot move the write.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        lo0_d        = lo0_q;
        lo1_d        = lo1_q;
        index_d      = index_q;
        lat_d        = lat_q;
        flush_d      = 1'b0;
        resp_hi_d    = resp_hi_q;
        resp_lo0_d   = resp_lo0_q;
        resp_lo1_d   = resp_lo1_q;
        resp_index_d = resp_index_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_if.req_valid) begin
                    op_d  = op_if.req_op;
                    hi_d  = op_if.cp0_entryhi;
                    lo0_d = op_if.cp0_entrylo0;
                    lo1_d = op_if.cp0_entrylo1;
                    lat_d = '0;
                    unique case (op_if.req_op)
                        TLB_OP_R: begin
                            index_d = tlb_index_t'(op_if.cp0_index[IW-1:0]);
                            state_d = ST_RD_WAIT;
                        end
                        TLB_OP_WI: begin
                            index_d = tlb_index_t'(op_if.cp0_index[IW-1:0]);
                            state_d = ST_WRITE;
                        end
                        TLB_OP_WR: begin
                            index_d = tlb_index_t'(random_q);
                            state_d = ST_WRITE;
                        end
                        TLB_OP_P: begin
                            state_d = ST_PR_WAIT;
                        end
                    endcase
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == 3'(READ_LAT - 1)) begin
                    resp_hi_d  = tlb_unpack_hi(tlbrw_rdata);
                    resp_lo0_d = tlb_unpack_lo0(tlbrw_rdata);
                    resp_lo1_d = tlb_unpack_lo1(tlbrw_rdata);
                    state_d    = ST_RESP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_PR_WAIT: begin
                if (lat_q == 3'(PROBE_LAT - 1)) begin
                    resp_index_d = {tlbp_index[31], 31'(tlbp_index[IW-1:0])};
                    state_d      = ST_RESP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_WRITE: begin
                flush_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (op_if.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, latency counter, flush pulse and writeback registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q         <= TLB_OP_R;
            hi_q         <= '0;
            lo0_q        <= '0;
            lo1_q        <= '0;
            index_q      <= '0;
            lat_q        <= '0;
            flush_q      <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo0_q   <= '0;
            resp_lo1_q   <= '0;
            resp_index_q <= '0;
        end else begin
            op_q         <= op_d;
            hi_q         <= hi_d;
            lo0_q        <= lo0_d;
            lo1_q        <= lo1_d;
            index_q      <= index_d;
            lat_q        <= lat_d;
            flush_q      <= flush_d;
            resp_hi_q    <= resp_hi_d;
            resp_lo0_q   <= resp_lo0_d;
            resp_lo1_q   <= resp_lo1_d;
            resp_index_q <= resp_index_d;
        end
    end

    assign op_if.req_ready     = (state_q == ST_IDLE);
    assign op_if.resp_valid    = (state_q == ST_RESP);
    assign op_if.resp_op       = op_q;
    assign op_if.resp_entryhi  = resp_hi_q;
    assign op_if.resp_entrylo0 = resp_lo0_q;
    assign op_if.resp_entrylo1 = resp_lo1_q;
    assign op_if.resp_index    = resp_index_q;

    assign random_out    = 32'(random_q);
    assign tlbrw_index   = index_q;
    assign tlbrw_we      = (state_q == ST_WRITE);
    assign tlbrw_wdata   = (state_q == ST_WRITE) ? tlb_pack(hi_q, lo0_q, lo1_q) : '0;
    assign tlbp_entry_hi = (state_q == ST_PR_WAIT) ? hi_q : 32'h0;
    assign tlb_flush     = flush_q;
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - randomized scoreboard bench for tlb_op_unit
module tb_tlb_op_unit;
    import tlb_op_unit_pkg::*;

    localparam int N  = 16;
    localparam int RL = 2;
    localparam int PL = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tlb_op_unit_if bus ();
    logic [31:0] cp0_wired = 32'd0;
    logic        wired_we = 1'b0;
    logic [31:0] random_out;
    tlb_index_t  tlbrw_index;
    logic        tlbrw_we;
    tlb_entry_t  tlbrw_wdata;
    tlb_entry_t  tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;
    logic        tlb_flush;

    tlb_op_unit #(.TLB_ENTRIES(N), .READ_LAT(RL), .PROBE_LAT(PL)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .op_if         (bus),
        .cp0_wired     (cp0_wired),
        .wired_we      (wired_we),
        .random_out    (random_out),
        .tlbrw_index   (tlbrw_index),
        .tlbrw_we      (tlbrw_we),
        .tlbrw_wdata   (tlbrw_wdata),
        .tlbrw_rdata   (tlbrw_rdata),
        .tlbp_entry_hi (tlbp_entry_hi),
        .tlbp_index    (tlbp_index),
        .tlb_flush     (tlb_flush)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // MMU model: entry storage plus a probe responder that only answers after PL cycles on the right key.
    tlb_entry_t mmu_mem [64] = '{default: '0};
    always @(posedge clk) if (tlbrw_we) mmu_mem[tlbrw_index] <= tlbrw_wdata;
    assign tlbrw_rdata = mmu_mem[tlbrw_index];

    logic [31:0] probe_key = 32'h0;
    logic [31:0] probe_result = 32'h0;
    int pcnt = 0;
    always @(posedge clk) pcnt <= (probe_key != 0 && tlbp_entry_hi == probe_key) ? pcnt + 1 : 0;
    assign tlbp_index = (probe_key != 0 && tlbp_entry_hi == probe_key && pcnt >= PL - 1) ? probe_result : 32'h5a5a_a5a5;

    // Reference Random: value held during the current cycle.
    logic [31:0] mrand = N - 1;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)                               mrand <= N - 1;
        else if (wired_we)                         mrand <= N - 1;
        else if (mrand <= cp0_wired || mrand == 0) mrand <= N - 1;
        else                                       mrand <= mrand - 1;
    end

    always @(negedge clk) check("random", random_out, mrand);

    // Reference register file as CP0 would read it back.
    logic [31:0] ref_hi  [N] = '{default: '0};
    logic [31:0] ref_lo0 [N] = '{default: '0};
    logic [31:0] ref_lo1 [N] = '{default: '0};

    typedef struct { tlb_op_t op; logic [31:0] hi; logic [31:0] lo0; logic [31:0] lo1; logic [31:0] idx; } resp_exp_t;
    typedef struct { int idx; logic [31:0] hi; logic [31:0] lo0; logic [31:0] lo1; } wr_exp_t;
    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    // Write monitor: one strobe per expected write, flush exactly one cycle later.
    logic prev_we = 1'b0;
    logic [31:0] last_wr_index = 32'hffff_ffff;
    always @(negedge clk) begin
        wr_exp_t w;
        if (tlbrw_we || prev_we || tlb_flush) check("flush_after_we", {31'b0, tlb_flush}, {31'b0, prev_we});
        if (tlbrw_we) begin
            last_wr_index = 32'(tlbrw_index);
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got index %0d, required no write", tlbrw_index);
            end else begin
                w = wr_q.pop_front();
                check("wr_index", 32'(tlbrw_index), 32'(w.idx));
                check("wr_hi", {tlbrw_wdata.vpn2, 5'b0, tlbrw_wdata.asid}, w.hi);
                check("wr_lo0", {6'b0, tlbrw_wdata.pfn0, tlbrw_wdata.c0, tlbrw_wdata.d0, tlbrw_wdata.v0, tlbrw_wdata.g}, w.lo0);
                check("wr_lo1", {6'b0, tlbrw_wdata.pfn1, tlbrw_wdata.c1, tlbrw_wdata.d1, tlbrw_wdata.v1, tlbrw_wdata.g}, w.lo1);
            end
        end
        prev_we = tlbrw_we;
    end

    // Response monitor: pops on handshake, checks stability while stalled.
    logic held = 1'b0;
    logic [31:0] h_op, h_hi, h_lo0, h_lo1, h_idx;
    always @(negedge clk) begin
        resp_exp_t e;
        if (!resetn) begin
            held = 1'b0;
        end else if (bus.resp_valid) begin
            check("req_ready_during_resp", {31'b0, bus.req_ready}, 32'd0);
            if (held) begin
                check("stall_op", 32'(bus.resp_op), h_op);
                check("stall_hi", bus.resp_entryhi, h_hi);
                check("stall_lo0", bus.resp_entrylo0, h_lo0);
                check("stall_lo1", bus.resp_entrylo1, h_lo1);
                check("stall_idx", bus.resp_index, h_idx);
            end
            if (bus.resp_ready) begin
                held = 1'b0;
                if (resp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got op %0d, required no response", bus.resp_op);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_op", 32'(bus.resp_op), 32'(e.op));
                    if (e.op == TLB_OP_R) begin
                        check("resp_entryhi", bus.resp_entryhi, e.hi);
                        check("resp_entrylo0", bus.resp_entrylo0, e.lo0);
                        check("resp_entrylo1", bus.resp_entrylo1, e.lo1);
                    end
                    if (e.op == TLB_OP_P) check("resp_index", bus.resp_index, e.idx);
                end
            end else begin
                held  = 1'b1;
                h_op  = 32'(bus.resp_op);
                h_hi  = bus.resp_entryhi;
                h_lo0 = bus.resp_entrylo0;
                h_lo1 = bus.resp_entrylo1;
                h_idx = bus.resp_index;
            end
        end else if (held) begin
            held = 1'b0;
            check("resp_dropped_while_stalled", {31'b0, bus.resp_valid}, 32'd1);
        end
    end

    logic hold_ready = 1'b0;
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) fail_now("req_ready_timeout");
    endtask

    // Called at a negedge with the unit idle; the request is accepted at the next posedge.
    task automatic issue_now(input tlb_op_t op, input logic [31:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] presult,
                             input logic wwe, input logic expect_it);
        logic [31:0] h;
        resp_exp_t e;
        wr_exp_t w;
        int wi;
        logic g;
        h = (op == TLB_OP_P) ? (hi | 32'h2000) : hi;
        bus.req_op = op;
        bus.cp0_index = idx;
        bus.cp0_entryhi = h;
        bus.cp0_entrylo0 = lo0;
        bus.cp0_entrylo1 = lo1;
        wired_we = wwe;
        bus.req_valid = 1'b1;
        if (expect_it) begin
            e.op = op; e.hi = 0; e.lo0 = 0; e.lo1 = 0; e.idx = 0;
            if (op == TLB_OP_R) begin
                wi = int'(idx % N);
                e.hi = ref_hi[wi];
                e.lo0 = ref_lo0[wi];
                e.lo1 = ref_lo1[wi];
            end else if (op == TLB_OP_P) begin
                probe_key = h;
                probe_result = presult;
                e.idx = presult & 32'h8000_000f;
            end else begin
                wi = (op == TLB_OP_WR) ? int'(mrand) : int'(idx % N);
                g = lo0[0] & lo1[0];
                ref_hi[wi]  = h & 32'hffff_e0ff;
                ref_lo0[wi] = (lo0 & 32'h03ff_fffe) | {31'b0, g};
                ref_lo1[wi] = (lo1 & 32'h03ff_fffe) | {31'b0, g};
                w.idx = wi; w.hi = ref_hi[wi]; w.lo0 = ref_lo0[wi]; w.lo1 = ref_lo1[wi];
                wr_q.push_back(w);
            end
            resp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wired_we = 1'b0;
    endtask

    task automatic issue(input tlb_op_t op, input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] presult);
        wait_idle();
        issue_now(op, idx, hi, lo0, lo1, presult, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((resp_q.size() != 0 || bus.resp_valid || !bus.req_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (resp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        tlb_op_t op;
        logic [31:0] pr;
        bus.req_valid = 1'b0;
        bus.req_op = TLB_OP_R;
        bus.cp0_index = 0;
        bus.cp0_entryhi = 0;
        bus.cp0_entrylo0 = 0;
        bus.cp0_entrylo1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_random_out", random_out, 32'd15);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_tlbrw_we", {31'b0, tlbrw_we}, 32'd0);
        check("rst_tlb_flush", {31'b0, tlb_flush}, 32'd0);
        check("rst_tlbrw_index", 32'(tlbrw_index), 32'd0);
        check("rst_tlbp_entry_hi", tlbp_entry_hi, 32'd0);
        resetn = 1'b1;

        // Random countdown with Wired=0 then Wired=4 (checked every cycle by the Random monitor).
        repeat (40) @(negedge clk);
        cp0_wired = 32'd4;
        repeat (30) @(negedge clk);
        cp0_wired = 32'd0;

        // Directed write, readback and probes.
        issue(TLB_OP_WI, 32'd5, 32'h0040_2012, 32'h0000_0107, 32'h0000_0147, 32'd0);
        issue(TLB_OP_R, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0);
        issue(TLB_OP_R, 32'd21, 32'd0, 32'd0, 32'd0, 32'd0);
        issue(TLB_OP_P, 32'd0, 32'h1234_5000, 32'd0, 32'd0, 32'h8000_0000);
        issue(TLB_OP_P, 32'd0, 32'h0040_2012, 32'd0, 32'd0, 32'h0000_0003);
        issue(TLB_OP_P, 32'd0, 32'h0abc_0000, 32'd0, 32'd0, 32'h7fff_fff3);
        issue(TLB_OP_P, 32'd0, 32'h0def_0000, 32'd0, 32'd0, 32'h8000_00a7);
        drain();

        // TLBWR captures Random at accept, also when Wired is written that same cycle.
        for (int k = 0; k < 2; k++) begin
            t = 0;
            @(negedge clk);
            while (!(bus.req_ready && mrand == 9) && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (mrand != 9) fail_now("wait_random_9");
            issue_now(TLB_OP_WR, 32'd2, 32'h7777_6055 + k, 32'h0123_4567, 32'h0765_4321, 32'd0, k == 1, 1'b1);
            drain();
            check("tlbwr_landed_index", last_wr_index, 32'd9);
        end
        issue(TLB_OP_R, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0);
        drain();

        // Stalled response stays stable and blocks new requests.
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        issue(TLB_OP_R, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0);
        t = 0;
        while (!bus.resp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
            check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
            check("hold_entryhi", bus.resp_entryhi, 32'h0040_2012);
            @(negedge clk);
        end
        hold_ready = 1'b0;
        drain();

        // Reset while in WRITE aborts the write and the response.
        wait_idle();
        issue_now(TLB_OP_WI, 32'd7, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 1'b0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_we", {31'b0, tlbrw_we}, 32'd0);
        check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_we", {31'b0, tlbrw_we}, 32'd0);
            check("post_abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
            check("post_abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
        end
        issue(TLB_OP_R, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0);
        drain();

        // Randomized mix of all operations with Wired and wired_we activity.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) cp0_wired = $urandom_range(0, 20);
            op = tlb_op_t'($urandom_range(0, 3));
            pr = ($urandom_range(0, 1) == 0) ? (32'h8000_0000 | ($urandom & 32'h7fff_ffff)) : ($urandom & 32'h7fff_ffff);
            wait_idle();
            issue_now(op, $urandom_range(0, 31), $urandom, $urandom, $urandom, pr, $urandom_range(0, 7) == 0, 1'b1);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
